// File: rtl/music_seq_ctrl.sv
// rtl/music_seq_ctrl.sv - note-period ROM playback sequencer with square-wave buzzer output
//
// Steps a ROM address once per beat and latches the note half-period that the
// ROM returns. The buzzer toggles every note_reg cycles while playing.
// Optional build macro: MUSIC_ARTIC_EN adds a silent tail at the end of each beat.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         pulse: begin playback at address 0 with track_sel_i latched
//   stop_i          pulse: abort playback (no done pulse)
//   pause_i         pulse: toggle PLAY <-> PAUSE
//   loop_en_i       level: wrap to address 0 after the last step
//   track_sel_i     track chosen at start
//   rom_addr_o      ROM address
//   rom_track_o     latched track, selects the ROM instance
//   rom_note_i      registered ROM data, valid one clk after address/track change
//   buzzer_o        square-wave audio
//   playing_o       high in FETCH, LOAD, PLAY, PAUSE
//   paused_o        high in PAUSE
//   done_o          one-cycle pulse on natural end of song

module music_seq_ctrl #(
    parameter int BEAT_CYCLES  = 6250000,
    parameter int ADDR_W       = 7,
    parameter int SONG_LEN     = 128,
    parameter int NOTE_W       = 20,
    parameter int TRK_W        = 1,
    parameter int REST_PERIOD  = 2500,
    parameter int ARTIC_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              pause_i,
    input  logic              loop_en_i,
    input  logic [TRK_W-1:0]  track_sel_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [TRK_W-1:0]  rom_track_o,
    input  logic [NOTE_W-1:0] rom_note_i,
    output logic              buzzer_o,
    output logic              playing_o,
    output logic              paused_o,
    output logic              done_o
);

    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    // First beat count of the silent tail; clamped so a tail longer than the beat mutes it all.
    localparam int ARTIC_START = (ARTIC_CYCLES < BEAT_CYCLES) ? (BEAT_CYCLES - ARTIC_CYCLES) : 0;

`ifdef MUSIC_ARTIC_EN
    localparam bit ARTIC_EN = 1'b1;
`else
    localparam bit ARTIC_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_PAUSE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TRK_W-1:0]    track_q, track_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [NOTE_W-1:0]   tone_q, tone_d;
    logic                buzzer_q, buzzer_d;
    logic                done_q, done_d;

    logic note_silent;
    logic last_beat;
    logic last_step;
    logic tone_wrap;
    logic artic_mute;

    assign note_silent = (note_q == '0) || (note_q == NOTE_W'(REST_PERIOD));
    assign last_beat   = (beat_q == BEAT_W'(BEAT_CYCLES - 1));
    assign last_step   = (addr_q == ADDR_W'(SONG_LEN - 1));
    assign tone_wrap   = (tone_q == (note_q - NOTE_W'(1)));
    assign artic_mute  = ARTIC_EN && (state_q == S_PLAY) && (beat_q >= BEAT_W'(ARTIC_START));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        track_d  = track_q;
        note_d   = note_q;
        beat_d   = beat_q;
        tone_d   = tone_q;
        buzzer_d = buzzer_q;
        done_d   = 1'b0;

        if (stop_i && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            addr_d   = '0;
            beat_d   = '0;
            tone_d   = '0;
            buzzer_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // stop in the same cycle outranks start
                    if (start_i && !stop_i) begin
                        track_d = track_sel_i;
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    note_d   = rom_note_i;
                    tone_d   = '0;
                    beat_d   = '0;
                    buzzer_d = 1'b0;
                    state_d  = S_PLAY;
                end
                S_PLAY: begin
                    if (pause_i) begin
                        // Freeze everything on the pausing cycle so resume picks up exactly here.
                        state_d = S_PAUSE;
                    end else begin
                        if (note_silent) begin
                            tone_d   = '0;
                            buzzer_d = 1'b0;
                        end else if (tone_wrap) begin
                            tone_d   = '0;
                            buzzer_d = ~buzzer_q;
                        end else begin
                            tone_d = tone_q + NOTE_W'(1);
                        end

                        if (last_beat) begin
                            if (!last_step) begin
                                addr_d  = addr_q + ADDR_W'(1);
                                state_d = S_FETCH;
                            end else if (loop_en_i) begin
                                addr_d  = '0;
                                state_d = S_FETCH;
                            end else begin
                                addr_d   = '0;
                                beat_d   = '0;
                                tone_d   = '0;
                                buzzer_d = 1'b0;
                                done_d   = 1'b1;
                                state_d  = S_IDLE;
                            end
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
                S_PAUSE: begin
                    if (pause_i) begin
                        state_d = S_PLAY;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            track_q  <= '0;
            note_q   <= '0;
            beat_q   <= '0;
            tone_q   <= '0;
            buzzer_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            track_q  <= track_d;
            note_q   <= note_d;
            beat_q   <= beat_d;
            tone_q   <= tone_d;
            buzzer_q <= buzzer_d;
            done_q   <= done_d;
        end
    end

    // Pause and the articulation tail mute the pin without disturbing the tone phase.
    assign buzzer_o    = buzzer_q && (state_q != S_PAUSE) && !artic_mute;
    assign rom_addr_o  = addr_q;
    assign rom_track_o = track_q;
    assign playing_o   = (state_q != S_IDLE);
    assign paused_o    = (state_q == S_PAUSE);
    assign done_o      = done_q;

endmodule

// File: doc/music_seq_ctrl.md
Name: music_seq_ctrl

Overview:
- Playback sequencer for the note-period ROM tracks. Steps a ROM address once per beat and captures the returned half-period count.
- Drives a square-wave buzzer output from that count.
- Handles start/stop/pause, selecting one of NUM_TRACKS tracks, and looping. Sits between the game control FSM and the audio pin.

Parameters:
BEAT_CYCLES, 6250000, clk cycles per ROM step (125 ms at 50 MHz); minimum 2
ADDR_W, 7, ROM address width
SONG_LEN, 128, number of steps per track; last address is SONG_LEN-1
NOTE_W, 20, width of note half-period word
TRK_W, 1, track select width; NUM_TRACKS = 2**TRK_W
REST_PERIOD, 2500, note word treated as silence (0 is also silence)
ARTIC_CYCLES, 500000, silent tail per beat; used only with MUSIC_ARTIC_EN

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
start  in  1  one-cycle pulse: begin playback from address 0
stop  in  1  one-cycle pulse: abort playback
pause  in  1  one-cycle pulse: toggle pause while playing
loop_en  in  1  level: wrap to address 0 after the last step instead of finishing
track_sel  in  TRK_W  track chosen at start
rom_addr  out  ADDR_W  ROM address
rom_track  out  TRK_W  latched track; muxes the ROM instances
rom_note  in  NOTE_W  registered ROM output, valid 1 clk after rom_addr/rom_track change
buzzer  out  1  square-wave audio
playing  out  1  high in FETCH, LOAD, PLAY, PAUSE
paused  out  1  high in PAUSE
done  out  1  one-cycle pulse on natural end of song (not on stop)

Behaviour:
Reset:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: state=IDLE, rom_addr=0, rom_track=0, buzzer=0, playing=0, paused=0, done=0. All counters 0, note register 0.
- Reset mid-playback takes effect immediately.

States:
- IDLE:
  - start=1 -> latch rom_track<=track_sel, rom_addr<=0, go FETCH.
  - pause is ignored.
- FETCH (1 cycle): wait for ROM latency -> LOAD.
- LOAD (1 cycle):
  - note_reg<=rom_note, tone counter<=0, buzzer<=0, beat counter<=0 -> PLAY.
- PLAY:
  - Beat counter increments each cycle.
  - When it reaches BEAT_CYCLES-1:
    - rom_addr!=SONG_LEN-1: rom_addr<=rom_addr+1 -> FETCH.
    - rom_addr==SONG_LEN-1 and loop_en=1: rom_addr<=0 -> FETCH. No done pulse.
    - rom_addr==SONG_LEN-1 and loop_en=0: done<=1 for one cycle, rom_addr<=0 -> IDLE.
  - pause=1 -> PAUSE.
- PAUSE:
  - Beat counter, tone counter and rom_addr are frozen; buzzer is forced 0.
  - pause=1 -> PLAY; counting resumes from the frozen values.
- Step timing: each ROM step occupies BEAT_CYCLES+2 cycles (FETCH + LOAD + BEAT_CYCLES of PLAY).

Tone generator (PLAY only):
- Silent note (note_reg==0 or note_reg==REST_PERIOD): buzzer=0, tone counter held at 0.
- Otherwise the tone counter counts 0..note_reg-1. On reaching note_reg-1: buzzer toggles, counter <= 0.
- Output period is 2*note_reg clk cycles. First toggle occurs note_reg cycles after entering PLAY.
- In FETCH and LOAD the buzzer holds its value until LOAD clears it.

Priority and boundary cases:
- Priority: stop > start > pause.
- stop in any non-IDLE state -> IDLE next cycle; buzzer=0, rom_addr=0, no done pulse.
- stop in IDLE: no effect.
- start while playing (FETCH, LOAD, PLAY, PAUSE): ignored.
- track_sel changes after start: ignored until the next start.
- loop_en is sampled only at the last-step boundary.
- Counter widths are sized by $clog2 of BEAT_CYCLES and 2**NOTE_W; no wrap before the compare.

Optional Feature:
MUSIC_ARTIC_EN:
- Defined: in PLAY, buzzer is forced 0 while beat counter >= BEAT_CYCLES-ARTIC_CYCLES, so consecutive identical notes are audibly separated. The tone counter keeps running.
- Undefined: no silent tail; identical consecutive notes sound continuous. ARTIC_CYCLES is unused.

Test Plan:
Common setup: BEAT_CYCLES=8, SONG_LEN=4, ADDR_W=2, ROM model track0 = {4, 2500, 3, 3}, track1 = {0, 5, 5, 5}.

1. Play to end: start pulse, track_sel=0, loop_en=0.
   - rom_addr sequence 0,1,2,3 with 10 cycles per step.
   - Step 0: buzzer toggles every 4 cycles. Step 1: buzzer stays 0.
   - done pulses exactly once, 40 cycles after start; playing then falls.
2. Loop: loop_en=1.
   - After address 3, rom_addr returns to 0 with no done pulse.
   - Continues until stop; after stop, next-cycle playing=0, buzzer=0, rom_addr=0.
3. Pause: pause pulse at PLAY step 2 cycle 3.
   - paused=1, buzzer=0, rom_addr held for 20 cycles.
   - Second pause pulse: remaining 5 beat cycles complete, then step 3 begins.
4. Priority: start and stop asserted in the same cycle while IDLE -> stays IDLE.
   - Then start with track_sel=1; change track_sel to 0 mid-song -> rom_track stays 1; step 0 buzzer is silent.
5. Reset: rst_n low during PLAY step 2 -> all outputs 0 immediately.
   - After release, stays IDLE until the next start.
6. MUSIC_ARTIC_EN defined, ARTIC_CYCLES=2, track0 step 2 -> buzzer forced 0 for beat cycles 6-7 of each step.
